spike_rate_counter: RTL and testbench
=====================================

# spike_rate_counter

Measures the firing rate of the LIF neuron. It counts rising edges of the neuron's spike output over a fixed window of clock cycles and presents the saturated count as a held 4-bit value. That value drives the seven-segment decoder's `counter` input. It is the producer end of the `counter[3:0]` → `segments` display path and sits between the neuron core and the display decoder.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 1000: enabled clock cycles per measurement window; legal range ≥ 2.
- `TIMER_W`, default `$clog2(WINDOW_CYCLES)`: width of the window timer; must hold `WINDOW_CYCLES-1`.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `spike_in`  in  1  neuron spike output (level; may be 1-cycle pulse or multi-cycle high).
- `enable`  in  1  count/advance enable.
- `clear`  in  1  synchronous restart of the current window.
- `counter`  out  4  spike count of the last completed window; feeds the seg7 decoder.
- `overflow`  out  1  last completed window saw more than 15 spikes.
- `window_done`  out  1  one-cycle pulse: `counter`/`overflow` just updated.
- `dp`  out  1  heartbeat, toggles every completed window; drives the decimal point.

## Operation
- Internal state:
  - `spike_q` (registered `spike_in`).
  - `edge = spike_in & ~spike_q`.
  - `timer[TIMER_W-1:0]`.
  - `accum[3:0]`.
  - `ovf_acc`.
- `spike_q` samples `spike_in` every cycle regardless of `enable`/`clear`. A spike held high across an enable transition is not counted again.
- Counting (`enable`=1, `clear`=0):
  - `edge`=1 and `accum`<15: `accum` += 1.
  - `edge`=1 and `accum`=15: `accum` stays 15 and `ovf_acc` := 1.
- Window end: `enable`=1, `clear`=0, `timer`=`WINDOW_CYCLES-1`. At that edge:
  - `counter` := saturated (`accum` + `edge`).
  - `overflow` := `ovf_acc` | (`edge` & `accum`=15).
  - `window_done` := 1.
  - `dp` := ~`dp`.
  - `timer`, `accum`, `ovf_acc` := 0.
- Otherwise, with `enable`=1 and `clear`=0: `timer` += 1 and `window_done` := 0.
- `enable`=0: `timer`, `accum`, `ovf_acc` hold; edges ignored; outputs hold except `window_done` := 0.
- `clear`=1 (takes priority over `enable` and window end):
  - `timer`, `accum`, `ovf_acc` := 0.
  - An edge in that cycle is discarded.
  - `counter`, `overflow`, `dp` hold; `window_done` := 0.
- Two modes: IDLE (`enable`=0 or `clear`=1) and COUNT (`enable`=1). There is no other FSM state.
- Arithmetic: all counts are unsigned. `accum` never wraps; it saturates at 15.

## Timing
- Reset values: `counter`=0, `overflow`=0, `window_done`=0, `dp`=0; internal `timer`=0, `accum`=0, `ovf_acc`=0, `spike_q`=0. Outputs go to these values immediately on `rst` assertion, without waiting for a clock.
- Reset mid-window discards the partial count. The first window after `rst` deassertion ends on the `WINDOW_CYCLES`-th enabled rising edge.
- Edge latency: `spike_in` rising at edge t (with `spike_q`=0) increments `accum` at edge t.
- An edge on the final window cycle counts toward that window.
- Output latency: `counter`/`overflow`/`dp` change at the window-end edge. `window_done` is high for exactly the following cycle.
- `counter`, `overflow` and `dp` are stable for a full window. The decoder may sample them at any time.
- Window period: exactly `WINDOW_CYCLES` enabled, non-cleared cycles. Disabled cycles stretch the window one-for-one.
- Minimum spike spacing counted: one low cycle between highs. Alternating 1/0 input yields ⌈N/2⌉ edges in N cycles.

## Test plan
1. `WINDOW_CYCLES`=16, five 1-cycle spikes in window 1 → after 16 cycles: `counter`=5, `overflow`=0, `dp`=1, `window_done` high 1 cycle.
2. `spike_in` held high 8 cycles, then low → window result `counter`=1.
3. `WINDOW_CYCLES`=64, 20 alternating spikes → `counter`=15, `overflow`=1. Next window with 3 spikes → `counter`=3, `overflow`=0, `dp` back to 0.
4. Spike on cycle 15 of a 16-cycle window counts (`counter`=1). A spike coincident with `clear`=1 is discarded. `clear` mid-window restarts the 16-cycle period and keeps the previous `counter`.
5. `enable`=0 for 10 cycles mid-window with spikes applied → those spikes are ignored and `window_done` arrives 10 cycles late. `spike_in` high across re-enable → not counted.
6. `rst` asserted asynchronously mid-window, between clock edges, with `counter`=7 → all outputs are 0 before the next clock edge. After release, the first window completes after exactly 16 enabled cycles.

Source files
------------

// File: rtl/spike_rate_counter.sv
// -----------------------------------------------------------------------------
// spike_rate_counter
//
// Measures the firing rate of the LIF neuron. Rising edges of the spike
// output are counted over a fixed window of enabled clock cycles. At the end
// of each window the count, saturated to 4 bits, is latched and held for the
// seven-segment decoder.
//
// Parameters:
//   WINDOW_CYCLES : enabled clock cycles per measurement window (>= 2)
//   TIMER_W       : width of the window timer, must hold WINDOW_CYCLES-1
//
// Ports:
//   clk         in   system clock, rising-edge active
//   rst         in   asynchronous active-high reset
//   spike_in    in   neuron spike level (pulse or multi-cycle high)
//   enable      in   count / advance enable
//   clear       in   synchronous restart of the current window
//   counter     out  [3:0] spike count of the last completed window
//   overflow    out  last completed window saw more than 15 spikes
//   window_done out  one-cycle pulse after counter/overflow update
//   dp          out  heartbeat, toggles every completed window
// -----------------------------------------------------------------------------
module spike_rate_counter #(
    parameter int WINDOW_CYCLES = 1000,
    parameter int TIMER_W       = $clog2(WINDOW_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spike_in,
    input  logic       enable,
    input  logic       clear,
    output logic [3:0] counter,
    output logic       overflow,
    output logic       window_done,
    output logic       dp
);

    localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(WINDOW_CYCLES - 1);

    // The block is either idle (disabled or being cleared) or counting.
    // The mode is a pure function of the control inputs, so it needs no
    // state register of its own.
    typedef enum logic {
        MODE_IDLE  = 1'b0,
        MODE_COUNT = 1'b1
    } mode_t;

    mode_t              w_mode;

    logic               r_spike_q;
    logic [TIMER_W-1:0] r_timer;
    logic [3:0]         r_accum;
    logic               r_ovf_acc;
    logic [3:0]         r_counter;
    logic               r_overflow;
    logic               r_window_done;
    logic               r_dp;

    logic [TIMER_W-1:0] w_timer_next;
    logic [3:0]         w_accum_next;
    logic               w_ovf_acc_next;
    logic [3:0]         w_counter_next;
    logic               w_overflow_next;
    logic               w_window_done_next;
    logic               w_dp_next;

    logic               w_edge;
    logic               w_accum_full;
    logic [3:0]         w_accum_sat;
    logic               w_ovf_sat;

    // Edge detect against the previous sample. spike_q samples every cycle,
    // so a level held high across a disable/clear period never produces a
    // second edge.
    assign w_edge       = spike_in & ~r_spike_q;
    assign w_accum_full = (r_accum == 4'd15);
    // Accumulator including this cycle's edge, saturating at 15.
    assign w_accum_sat  = w_accum_full ? 4'd15 : (r_accum + {3'b000, w_edge});
    // Overflow is sticky once an edge arrives while already at 15.
    assign w_ovf_sat    = r_ovf_acc | (w_edge & w_accum_full);

    always_comb begin
        w_mode = (enable && !clear) ? MODE_COUNT : MODE_IDLE;
    end

    always_comb begin
        w_timer_next       = r_timer;
        w_accum_next       = r_accum;
        w_ovf_acc_next     = r_ovf_acc;
        w_counter_next     = r_counter;
        w_overflow_next    = r_overflow;
        w_window_done_next = 1'b0;
        w_dp_next          = r_dp;

        case (w_mode)
            MODE_COUNT: begin
                if (r_timer == LAST_TICK) begin
                    // Window end: the edge of this final cycle still counts.
                    w_counter_next     = w_accum_sat;
                    w_overflow_next    = w_ovf_sat;
                    w_window_done_next = 1'b1;
                    w_dp_next          = ~r_dp;
                    w_timer_next       = '0;
                    w_accum_next       = 4'd0;
                    w_ovf_acc_next     = 1'b0;
                end else begin
                    w_timer_next   = r_timer + 1'b1;
                    w_accum_next   = w_accum_sat;
                    w_ovf_acc_next = w_ovf_sat;
                end
            end
            default: begin
                // Clear restarts the window and drops any edge in this cycle;
                // plain disable just freezes the window.
                if (clear) begin
                    w_timer_next   = '0;
                    w_accum_next   = 4'd0;
                    w_ovf_acc_next = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spike_q     <= 1'b0;
            r_timer       <= '0;
            r_accum       <= 4'd0;
            r_ovf_acc     <= 1'b0;
            r_counter     <= 4'd0;
            r_overflow    <= 1'b0;
            r_window_done <= 1'b0;
            r_dp          <= 1'b0;
        end else begin
            r_spike_q     <= spike_in;
            r_timer       <= w_timer_next;
            r_accum       <= w_accum_next;
            r_ovf_acc     <= w_ovf_acc_next;
            r_counter     <= w_counter_next;
            r_overflow    <= w_overflow_next;
            r_window_done <= w_window_done_next;
            r_dp          <= w_dp_next;
        end
    end

    assign counter     = r_counter;
    assign overflow    = r_overflow;
    assign window_done = r_window_done;
    assign dp          = r_dp;

endmodule

// File: tb/tb_spike_rate_counter.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_counter
//
// Directed bench for spike_rate_counter. Two instances: one with a 16-cycle
// window (A) and one with a 64-cycle window (B) for the saturation case.
// Inputs change just after the falling edge; outputs are checked on the
// falling edge, half a period after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_spike_rate_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       sa, ea, ca;
    logic       sb, eb, cb;
    logic [3:0] cnt_a, cnt_b;
    logic       ovf_a, wd_a, dp_a;
    logic       ovf_b, wd_b, dp_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spike_rate_counter #(.WINDOW_CYCLES(16), .TIMER_W(4)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .spike_in    (sa),
        .enable      (ea),
        .clear       (ca),
        .counter     (cnt_a),
        .overflow    (ovf_a),
        .window_done (wd_a),
        .dp          (dp_a)
    );

    spike_rate_counter #(.WINDOW_CYCLES(64), .TIMER_W(6)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .spike_in    (sb),
        .enable      (eb),
        .clear       (cb),
        .counter     (cnt_b),
        .overflow    (ovf_b),
        .window_done (wd_b),
        .dp          (dp_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [3:0] c, input logic o,
                           input logic wd, input logic d);
        check({tag, ".counter"},     {4'b0, cnt_a}, {4'b0, c});
        check({tag, ".overflow"},    {7'b0, ovf_a}, {7'b0, o});
        check({tag, ".window_done"}, {7'b0, wd_a},  {7'b0, wd});
        check({tag, ".dp"},          {7'b0, dp_a},  {7'b0, d});
        $display("[TB] %s: A counter=%0d overflow=%0d window_done=%0d dp=%0d",
                 tag, cnt_a, ovf_a, wd_a, dp_a);
    endtask

    task automatic check_b(input string tag, input logic [3:0] c, input logic o,
                           input logic wd, input logic d);
        check({tag, ".counter"},     {4'b0, cnt_b}, {4'b0, c});
        check({tag, ".overflow"},    {7'b0, ovf_b}, {7'b0, o});
        check({tag, ".window_done"}, {7'b0, wd_b},  {7'b0, wd});
        check({tag, ".dp"},          {7'b0, dp_b},  {7'b0, d});
        $display("[TB] %s: B counter=%0d overflow=%0d window_done=%0d dp=%0d",
                 tag, cnt_b, ovf_b, wd_b, dp_b);
    endtask

    // One rising edge with the given inputs on instance A.
    task automatic step_a(input logic s, input logic e, input logic c);
        sa = s; ea = e; ca = c;
        @(negedge clk);
    endtask

    task automatic run_a(input int n, input logic s, input logic e);
        repeat (n) step_a(s, e, 1'b0);
    endtask

    // k one-cycle spikes separated by one low cycle: 2k enabled cycles.
    task automatic pulses_a(input int k);
        repeat (k) begin
            step_a(1'b1, 1'b1, 1'b0);
            step_a(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic step_b(input logic s, input logic e, input logic c);
        sb = s; eb = e; cb = c;
        @(negedge clk);
    endtask

    task automatic run_b(input int n, input logic s, input logic e);
        repeat (n) step_b(s, e, 1'b0);
    endtask

    task automatic pulses_b(input int k);
        repeat (k) begin
            step_b(1'b1, 1'b1, 1'b0);
            step_b(1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0;
        sa = 1'b0; ea = 1'b0; ca = 1'b0;
        sb = 1'b0; eb = 1'b0; cb = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        check_a("reset_a", 4'd0, 1'b0, 1'b0, 1'b0);
        check_b("reset_b", 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Window 1: five single-cycle spikes.
        pulses_a(5);
        run_a(5, 1'b0, 1'b1);
        check_a("t1_pre", 4'd0, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 1'b0);
        check_a("t1_end", 4'd5, 1'b0, 1'b1, 1'b1);

        // Window 2: spike held high for 8 cycles counts once.
        step_a(1'b1, 1'b1, 1'b0);
        check_a("t1_pulse_gone", 4'd5, 1'b0, 1'b0, 1'b1);
        run_a(7, 1'b1, 1'b1);
        run_a(7, 1'b0, 1'b1);
        check_a("t2_pre", 4'd5, 1'b0, 1'b0, 1'b1);
        step_a(1'b0, 1'b1, 1'b0);
        check_a("t2_end", 4'd1, 1'b0, 1'b1, 1'b0);

        // Window 3: the only spike arrives on the final window cycle.
        run_a(15, 1'b0, 1'b1);
        step_a(1'b1, 1'b1, 1'b0);
        check_a("t4_last_cycle", 4'd1, 1'b0, 1'b1, 1'b1);

        // Window 4: clear after 5 cycles with a coincident spike.
        run_a(5, 1'b0, 1'b1);
        step_a(1'b1, 1'b1, 1'b1);
        check_a("t4_clear_hold", 4'd1, 1'b0, 1'b0, 1'b1);
        step_a(1'b0, 1'b1, 1'b0);
        step_a(1'b1, 1'b1, 1'b0);
        step_a(1'b0, 1'b1, 1'b0);
        step_a(1'b1, 1'b1, 1'b0);
        run_a(11, 1'b0, 1'b1);
        check_a("t4_restart_pre", 4'd1, 1'b0, 1'b0, 1'b1);
        step_a(1'b0, 1'b1, 1'b0);
        check_a("t4_restart_end", 4'd2, 1'b0, 1'b1, 1'b0);

        // Window 5: 3 spikes in 5 cycles, 10 disabled cycles with spikes,
        // spike still high when re-enabled.
        pulses_a(2);
        step_a(1'b1, 1'b1, 1'b0);
        step_a(1'b0, 1'b0, 1'b0);
        check_a("t5_disabled", 4'd2, 1'b0, 1'b0, 1'b0);
        repeat (4) begin
            step_a(1'b1, 1'b0, 1'b0);
            step_a(1'b0, 1'b0, 1'b0);
        end
        step_a(1'b1, 1'b0, 1'b0);
        check_a("t5_disabled_end", 4'd2, 1'b0, 1'b0, 1'b0);
        run_a(2, 1'b1, 1'b1);
        run_a(8, 1'b0, 1'b1);
        check_a("t5_pre", 4'd2, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 1'b0);
        check_a("t5_end", 4'd3, 1'b0, 1'b1, 1'b1);

        // Window 6: seven spikes, then reset mid-window 7 between edges.
        pulses_a(7);
        run_a(1, 1'b0, 1'b1);
        step_a(1'b0, 1'b1, 1'b0);
        check_a("t6_count7", 4'd7, 1'b0, 1'b1, 1'b0);
        pulses_a(1);
        step_a(1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_a("t6_async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step_a(1'b1, 1'b1, 1'b0);
        run_a(14, 1'b0, 1'b1);
        check_a("t6_after_pre", 4'd0, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 1'b0);
        check_a("t6_after_end", 4'd1, 1'b0, 1'b1, 1'b1);
        ea = 1'b0;

        // Instance B, 64-cycle window: 20 spikes saturate to 15 with overflow.
        pulses_b(20);
        run_b(23, 1'b0, 1'b1);
        check_b("t3_pre", 4'd0, 1'b0, 1'b0, 1'b0);
        step_b(1'b0, 1'b1, 1'b0);
        check_b("t3_sat", 4'd15, 1'b1, 1'b1, 1'b1);
        pulses_b(3);
        run_b(57, 1'b0, 1'b1);
        check_b("t3_next_pre", 4'd15, 1'b1, 1'b0, 1'b1);
        step_b(1'b0, 1'b1, 1'b0);
        check_b("t3_next", 4'd3, 1'b0, 1'b1, 1'b0);
        eb = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
